// File: rtl/instr_fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module  : instr_fetch_unit_if
// Brief   : Instruction-memory read bus between the fetch unit and imem.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_unit_if;
    logic        imem_rd;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;

    modport master (
        output imem_rd,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_rd,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : instr_fetch_unit
// Brief   : RV64I multicycle fetch stage: PC, imem read, IR, latency timeout.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int          TIMEOUT  = 15
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic               fetch_req,
    input  wire logic               pc_load,
    input  wire logic [63:0]        pc_next,
    instr_fetch_unit_if.master      imem,
    output logic      [63:0]        pc,
    output logic      [31:0]        instr,
    output logic      [6:0]         opcode,
    output logic      [4:0]         rd,
    output logic      [2:0]         funct3,
    output logic      [4:0]         rs1,
    output logic      [4:0]         rs2,
    output logic      [6:0]         funct7,
    output logic                    instr_valid,
    output logic                    fetch_err
);

    localparam logic [31:0] c_nop     = 32'h0000_0013;
    localparam logic [7:0]  c_timeout = 8'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WAIT  = 2'd2,
        S_READY = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [63:0] r_pc, w_pc_nxt;
    logic [31:0] r_ir;
    logic [7:0]  r_count, w_count_nxt, w_count_inc;
    logic        r_imem_rd;
    logic [63:0] r_imem_addr;
    logic        r_instr_valid;
    logic        r_fetch_err;
    logic        w_ir_load;
    logic        w_err_set;
    logic        w_target_ok;

    assign w_target_ok = (pc_next[1:0] == 2'b00);
    assign w_count_inc = r_count + 8'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_count_nxt = r_count;
        w_ir_load   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A misaligned redirect flags the error but never moves the PC.
                if (pc_load) begin
                    if (w_target_ok) w_pc_nxt  = pc_next;
                    else             w_err_set = 1'b1;
                end
                if (fetch_req) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                w_count_nxt = 8'd0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (imem.imem_valid) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = S_READY;
                end else begin
                    w_count_nxt = w_count_inc;
                    if (w_count_inc == c_timeout) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_READY: begin
                if (fetch_req) begin
                    if (!pc_load)        w_pc_nxt  = r_pc + 64'd4;
                    else if (w_target_ok) w_pc_nxt = pc_next;
                    else                  w_err_set = 1'b1;
                    w_state_nxt = S_REQ;
                end else if (pc_load) begin
                    if (w_target_ok) w_pc_nxt  = pc_next;
                    else             w_err_set = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_ir          <= c_nop;
            r_count       <= 8'd0;
            r_imem_rd     <= 1'b0;
            r_imem_addr   <= 64'd0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_count       <= w_count_nxt;
            r_imem_rd     <= (w_state_nxt == S_REQ);
            r_instr_valid <= (w_state_nxt == S_READY);
            if (w_state_nxt == S_REQ) r_imem_addr <= w_pc_nxt;
            if (w_ir_load)            r_ir        <= imem.imem_rdata;
            if (w_err_set)            r_fetch_err <= 1'b1;
        end
    end

    assign imem.imem_rd   = r_imem_rd;
    assign imem.imem_addr = r_imem_addr;
    assign pc             = r_pc;
    assign instr          = r_ir;
    assign opcode         = r_ir[6:0];
    assign rd             = r_ir[11:7];
    assign funct3         = r_ir[14:12];
    assign rs1            = r_ir[19:15];
    assign rs2            = r_ir[24:20];
    assign funct7         = r_ir[31:25];
    assign instr_valid    = r_instr_valid;
    assign fetch_err      = r_fetch_err;

endmodule

`default_nettype wire
